// File: rtl/serial_pattern_detector_if.sv
// Serial pattern detector bus.
//   en, din, clr       : sample enable, serial bit, synchronous clear (driver -> detector)
//   match, match_count : one-cycle match pulse and saturating match count (detector -> driver)
//   sat, busy          : count-at-all-ones flag and history-present flag (detector -> driver)
interface serial_pattern_detector_if #(
  parameter int unsigned CNT_W = 8
);
  logic             en;
  logic             din;
  logic             clr;
  logic             match;
  logic [CNT_W-1:0] match_count;
  logic             sat;
  logic             busy;

  modport master (
    output en, din, clr,
    input  match, match_count, sat, busy
  );

  modport slave (
    input  en, din, clr,
    output match, match_count, sat, busy
  );
endinterface

// File: rtl/serial_pattern_detector.sv
// Serial pattern detector: shifts din in on every enabled Clk edge and flags
// when the last N sampled bits equal PATTERN (MSB = oldest bit). Matches may
// overlap. A saturating counter records the number of matches.
//   Clk  : rising-edge clock
//   RST  : synchronous active-high reset (priority over clr)
//   bus  : slave side of serial_pattern_detector_if
//          en/din/clr in; match/match_count/sat/busy out, all registered
module serial_pattern_detector #(
  parameter int unsigned   N       = 4,
  parameter logic [N-1:0]  PATTERN = 4'b1011,
  parameter int unsigned   CNT_W   = 8
) (
  input  logic                        Clk,
  input  logic                        RST,
  serial_pattern_detector_if.slave    bus
);

  localparam int unsigned FW = $clog2(N + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [N-1:0]     shreg_q, shreg_d;
  logic [FW-1:0]    fill_q,  fill_d;
  logic             match_q, match_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic             sat_q,   sat_d;
  logic             busy_q,  busy_d;
  logic             full;

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    fill_d  = fill_q;
    match_d = 1'b0;
    cnt_d   = cnt_q;
    full    = 1'b0;

    if (bus.clr) begin
      state_d = IDLE;
      shreg_d = '0;
      fill_d  = '0;
      cnt_d   = '0;
    end else if (bus.en) begin
      shreg_d = {shreg_q[N-2:0], bus.din};
      unique case (state_q)
        IDLE: begin
          fill_d  = FW'(1);
          state_d = FILL;
        end
        FILL: begin
          fill_d = fill_q + FW'(1);
          // The N-th bit arrives on this edge: history is complete now.
          if (fill_q == FW'(N - 1)) begin
            state_d = RUN;
            full    = 1'b1;
          end
        end
        RUN: begin
          full = 1'b1;
        end
        default: begin
          state_d = IDLE;
          shreg_d = '0;
          fill_d  = '0;
        end
      endcase

      // Only compare once N real bits are held, so reset zeros never match.
      if (full && (shreg_d == PATTERN)) begin
        match_d = 1'b1;
        if (cnt_q != '1) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    end

    sat_d  = (cnt_d == '1);
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge Clk) begin
    if (RST) begin
      state_q <= IDLE;
      shreg_q <= '0;
      fill_q  <= '0;
      match_q <= 1'b0;
      cnt_q   <= '0;
      sat_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      fill_q  <= fill_d;
      match_q <= match_d;
      cnt_q   <= cnt_d;
      sat_q   <= sat_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.match       = match_q;
  assign bus.match_count = cnt_q;
  assign bus.sat         = sat_q;
  assign bus.busy        = busy_q;

endmodule

// File: tb/tb_serial_pattern_detector.sv
module tb_serial_pattern_detector;

  logic Clk = 1'b0;
  logic RST = 1'b1;
  always #5 Clk = ~Clk;

  serial_pattern_detector_if #(.CNT_W(8)) bus0 ();
  serial_pattern_detector_if #(.CNT_W(8)) bus1 ();
  serial_pattern_detector_if #(.CNT_W(2)) bus2 ();

  serial_pattern_detector #(.N(4), .PATTERN(4'b1011), .CNT_W(8)) u_main (
    .Clk(Clk), .RST(RST), .bus(bus0.slave));
  serial_pattern_detector #(.N(4), .PATTERN(4'b0000), .CNT_W(8)) u_zero (
    .Clk(Clk), .RST(RST), .bus(bus1.slave));
  serial_pattern_detector #(.N(4), .PATTERN(4'b1011), .CNT_W(2)) u_sat (
    .Clk(Clk), .RST(RST), .bus(bus2.slave));

  typedef struct {
    logic       rst;
    logic       en;
    logic       din;
    logic       clr;
    logic       m;
    logic [7:0] cnt;
    logic       sat;
    logic       busy;
  } vec_t;

  vec_t vecs[$];
  int unsigned pass_cnt = 0;
  int unsigned total_cnt = 0;

  function automatic vec_t mk(logic rst, logic en, logic din, logic clr,
                              logic m, logic [7:0] cnt, logic sat, logic busy);
    vec_t v;
    v.rst = rst; v.en = en; v.din = din; v.clr = clr;
    v.m = m; v.cnt = cnt; v.sat = sat; v.busy = busy;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
  endtask

  task automatic step;
    @(posedge Clk);
    #1;
  endtask

  initial begin
    bus0.en = 1'b0; bus0.din = 1'b0; bus0.clr = 1'b0;
    bus1.en = 1'b0; bus1.din = 1'b0; bus1.clr = 1'b0;
    bus2.en = 1'b0; bus2.din = 1'b0; bus2.clr = 1'b0;

    //                 rst en din clr   m  cnt  sat busy
    // reset held two cycles with en=1, din=1
    vecs.push_back(mk(1, 1, 1, 0,   0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 1, 0,   0, 0, 0, 0));
    // en=0 in IDLE stays idle
    vecs.push_back(mk(0, 0, 1, 0,   0, 0, 0, 0));
    // overlap: 1,0,1,1,0,1,1
    vecs.push_back(mk(0, 1, 1, 0,   0, 0, 0, 1));
    vecs.push_back(mk(0, 1, 0, 0,   0, 0, 0, 1));
    vecs.push_back(mk(0, 1, 1, 0,   0, 0, 0, 1));
    vecs.push_back(mk(0, 1, 1, 0,   1, 1, 0, 1));
    vecs.push_back(mk(0, 1, 0, 0,   0, 1, 0, 1));
    vecs.push_back(mk(0, 1, 1, 0,   0, 1, 0, 1));
    vecs.push_back(mk(0, 1, 1, 0,   1, 2, 0, 1));
    // clr beats en
    vecs.push_back(mk(0, 1, 1, 1,   0, 0, 0, 0));
    // en gating: 1,0,1 then 3 idle cycles with din toggling, then 1
    vecs.push_back(mk(0, 1, 1, 0,   0, 0, 0, 1));
    vecs.push_back(mk(0, 1, 0, 0,   0, 0, 0, 1));
    vecs.push_back(mk(0, 1, 1, 0,   0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0,   0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 1, 0,   0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0,   0, 0, 0, 1));
    vecs.push_back(mk(0, 1, 1, 0,   1, 1, 0, 1));
    // mid-stream clr: 1,0,1 then clr with din=1 (would complete 1011)
    vecs.push_back(mk(0, 0, 0, 1,   0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 1, 0,   0, 0, 0, 1));
    vecs.push_back(mk(0, 1, 0, 0,   0, 0, 0, 1));
    vecs.push_back(mk(0, 1, 1, 0,   0, 0, 0, 1));
    vecs.push_back(mk(0, 1, 1, 1,   0, 0, 0, 0));
    // 0,1,1 after clr: the discarded 1 must not form 1011
    vecs.push_back(mk(0, 1, 0, 0,   0, 0, 0, 1));
    vecs.push_back(mk(0, 1, 1, 0,   0, 0, 0, 1));
    vecs.push_back(mk(0, 1, 1, 0,   0, 0, 0, 1));
    // clr again, then 1,0,1,1 -> single match on final bit
    vecs.push_back(mk(0, 1, 1, 1,   0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 1, 0,   0, 0, 0, 1));
    vecs.push_back(mk(0, 1, 0, 0,   0, 0, 0, 1));
    vecs.push_back(mk(0, 1, 1, 0,   0, 0, 0, 1));
    vecs.push_back(mk(0, 1, 1, 0,   1, 1, 0, 1));
    // reset with clr simultaneously
    vecs.push_back(mk(1, 1, 1, 1,   0, 0, 0, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      RST      = vecs[i].rst;
      bus0.en  = vecs[i].en;
      bus0.din = vecs[i].din;
      bus0.clr = vecs[i].clr;
      step();
      chk("match", i, 32'(bus0.match),       32'(vecs[i].m));
      chk("count", i, 32'(bus0.match_count), 32'(vecs[i].cnt));
      chk("sat",   i, 32'(bus0.sat),         32'(vecs[i].sat));
      chk("busy",  i, 32'(bus0.busy),        32'(vecs[i].busy));
    end
    bus0.en = 1'b0; bus0.clr = 1'b0;

    // PATTERN=0000: reset zeros must not satisfy the pattern
    RST = 1'b1;
    step();
    RST = 1'b0;
    bus1.en = 1'b1;
    bus1.din = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("zero_match", i, 32'(bus1.match), (i >= 3) ? 32'd1 : 32'd0);
      chk("zero_count", i, 32'(bus1.match_count),
          (i == 3) ? 32'd1 : (i == 4) ? 32'd2 : 32'd0);
    end
    bus1.en = 1'b0;

    // Saturation with CNT_W=2: stream 1011011011011
    begin
      logic [12:0] stream;
      stream = 13'b1011011011011;
      bus2.en = 1'b1;
      for (int i = 0; i < 13; i++) begin
        int unsigned ecnt;
        bus2.din = stream[12 - i];
        step();
        ecnt = (i >= 9) ? 3 : (i >= 6) ? 2 : (i >= 3) ? 1 : 0;
        chk("sat_match", i, 32'(bus2.match),
            (i == 3 || i == 6 || i == 9 || i == 12) ? 32'd1 : 32'd0);
        chk("sat_count", i, 32'(bus2.match_count), ecnt);
        chk("sat_flag",  i, 32'(bus2.sat), (i >= 9) ? 32'd1 : 32'd0);
      end
      // RST together with clr clears everything
      RST = 1'b1;
      bus2.clr = 1'b1;
      bus2.din = 1'b1;
      step();
      chk("rstclr_match", 0, 32'(bus2.match), 32'd0);
      chk("rstclr_count", 0, 32'(bus2.match_count), 32'd0);
      chk("rstclr_sat",   0, 32'(bus2.sat), 32'd0);
      chk("rstclr_busy",  0, 32'(bus2.busy), 32'd0);
      RST = 1'b0;
      bus2.clr = 1'b0;
      bus2.en = 1'b0;
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
